if_id_fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register of the RV32I pipeline.
//  - Owns the PC and issues one word fetch at a time to instruction memory.
//  - Captures the returned word into IF/ID; id_instr feeds imm_gen and the decoder.
//  - Honours stall from the hazard unit and redirect (taken branch/jump) from EX.

---
 rtl/if_id_fetch_stage.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/if_id_fetch_stage.sv
// RV32I instruction fetch stage with IF/ID pipeline register.
// One outstanding fetch; stall parks the returned word, redirect flushes.
module if_id_fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_pc_plus4,
  output logic [31:0] id_instr
);

  typedef enum logic [1:0] {
    S_FETCH,
    S_WAIT,
    S_HOLD
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] hold_q, hold_d;
  logic        kill_q, kill_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_pc_q, id_pc_d;
  logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
  logic [31:0] id_instr_q, id_instr_d;

  logic        load;
  logic [31:0] load_instr;
  logic [31:0] redir_pc;
  logic [31:0] pc_plus4;

  assign redir_pc = redirect_pc & ~32'd3;
  assign pc_plus4 = pc_q + 32'd4;

  assign imem_req  = (state_q == S_FETCH) & ~redirect_i;
  assign imem_addr = pc_q;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    hold_d     = hold_q;
    kill_d     = kill_q;
    load       = 1'b0;
    load_instr = hold_q;
    unique case (state_q)
      S_FETCH: begin
        if (redirect_i) pc_d = redir_pc;
        else            state_d = S_WAIT;
      end
      S_WAIT: begin
        if (!imem_rvalid) begin
          if (redirect_i) begin
            pc_d   = redir_pc;
            kill_d = 1'b1;
          end
        end else if (kill_q || redirect_i) begin
          // stale or cancelled response
          kill_d  = 1'b0;
          state_d = S_FETCH;
          if (redirect_i) pc_d = redir_pc;
        end else if (!stall_i || !id_valid_q) begin
          load       = 1'b1;
          load_instr = imem_rdata;
          pc_d       = pc_plus4;
          state_d    = S_FETCH;
        end else begin
          hold_d  = imem_rdata;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (redirect_i) begin
          pc_d    = redir_pc;
          state_d = S_FETCH;
        end else if (!stall_i) begin
          load    = 1'b1;
          pc_d    = pc_plus4;
          state_d = S_FETCH;
        end
      end
      default: state_d = S_FETCH;
    endcase
  end

  always_comb begin
    id_valid_d    = id_valid_q;
    id_pc_d       = id_pc_q;
    id_pc_plus4_d = id_pc_plus4_q;
    id_instr_d    = id_instr_q;
    if (redirect_i) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end else if (load) begin
      id_valid_d    = 1'b1;
      id_pc_d       = pc_q;
      id_pc_plus4_d = pc_plus4;
      id_instr_d    = load_instr;
    end else if (!(stall_i && id_valid_q)) begin
      id_valid_d = 1'b0;
      id_instr_d = NOP_INSTR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= S_FETCH;
      pc_q          <= RESET_PC;
      hold_q        <= 32'd0;
      kill_q        <= 1'b0;
      id_valid_q    <= 1'b0;
      id_pc_q       <= 32'd0;
      id_pc_plus4_q <= 32'd4;
      id_instr_q    <= NOP_INSTR;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      hold_q        <= hold_d;
      kill_q        <= kill_d;
      id_valid_q    <= id_valid_d;
      id_pc_q       <= id_pc_d;
      id_pc_plus4_q <= id_pc_plus4_d;
      id_instr_q    <= id_instr_d;
    end
  end

  assign id_valid    = id_valid_q;
  assign id_pc       = id_pc_q;
  assign id_pc_plus4 = id_pc_plus4_q;
  assign id_instr    = id_instr_q;

endmodule
